pipe_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the stall and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Sources it resolves:
- load-use hazards
- taken branches and jumps resolved in EX
- instruction-fetch misses
- data-memory wait states
- ECALL-triggered drain-and-halt

It also keeps saturating stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipe_hazard_ctrl_if.sv | 59 +++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard
//               controller: sequencer state encoding, register-index width
//               and the hard-wired zero register index.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    // x0 is hard-wired to zero, so a "write" to it never creates a hazard.
    localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Bundle between the pipeline datapath and the hazard
//               controller.
//               master : datapath side (drives ID/EX/MEM status, receives
//                        stall/flush controls and perf counters)
//               slave  : controller side
//               Status in : id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd,
//                           ex_mem_read, ex_branch_taken, ecall_id,
//                           imem_valid, dmem_busy
//               Control out: pc_stall, ifid_stall, ifid_flush, idex_stall,
//                           idex_flush, exmem_stall, memwb_flush, halt,
//                           stall_cnt, flush_cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipe_ctrl_pkg::*;

    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic                 id_uses_rs1;
    logic                 id_uses_rs2;
    logic [REG_IDX_W-1:0] ex_rd;
    logic                 ex_mem_read;
    logic                 ex_branch_taken;
    logic                 ecall_id;
    logic                 imem_valid;
    logic                 dmem_busy;

    logic                 pc_stall;
    logic                 ifid_stall;
    logic                 ifid_flush;
    logic                 idex_stall;
    logic                 idex_flush;
    logic                 exmem_stall;
    logic                 memwb_flush;
    logic                 halt;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ecall_id, imem_valid, dmem_busy,
        input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, memwb_flush, halt, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ecall_id, imem_valid, dmem_busy,
        output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, memwb_flush, halt, stall_cnt, flush_cnt
    );

endinterface : pipe_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use hazard predicate. Flags the case
//               where the instruction in EX is a load whose destination is
//               a source register actually read by the instruction in ID.
//               Ports: id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
//                      ex_rd_i, ex_mem_read_i -> hazard_o
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 id_uses_rs1_i,
    input  logic                 id_uses_rs2_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_mem_read_i,
    output logic                 hazard_o
);

    logic w_rs1_match;
    logic w_rs2_match;

    assign w_rs1_match = id_uses_rs1_i && (ex_rd_i == id_rs1_i);
    assign w_rs2_match = id_uses_rs2_i && (ex_rd_i == id_rs2_i);

    assign hazard_o = ex_mem_read_i && (ex_rd_i != ZERO_REG) &&
                      (w_rs1_match || w_rs2_match);

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Central stall/flush sequencer for the 5-stage pipeline.
//               Resolves data-memory waits, taken branches, ECALL
//               drain-and-halt, load-use hazards and fetch misses, and keeps
//               saturating stall/flush performance counters.
//               Ports: clk, rst_n (async, active low),
//                      bus (pipe_hazard_ctrl_if.slave) carrying all status
//                      inputs and control/counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  bus
);

    // Drain counter just needs to hold DRAIN_CYCLES (>= 1).
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    state_t               state_q,     state_d;
    logic [DRAIN_W-1:0]   drain_q,     drain_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;

    logic w_hazard;
    logic w_pc_stall;
    logic w_ifid_stall;
    logic w_ifid_flush;
    logic w_idex_stall;
    logic w_idex_flush;
    logic w_exmem_stall;
    logic w_memwb_flush;
    logic w_halt;

    hazard_detect u_hazard_detect (
        .id_rs1_i      (bus.id_rs1),
        .id_rs2_i      (bus.id_rs2),
        .id_uses_rs1_i (bus.id_uses_rs1),
        .id_uses_rs2_i (bus.id_uses_rs2),
        .ex_rd_i       (bus.ex_rd),
        .ex_mem_read_i (bus.ex_mem_read),
        .hazard_o      (w_hazard)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            drain_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_stall  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_stall = 1'b0;
        w_memwb_flush = 1'b0;
        w_halt        = 1'b0;

        // Controls are forced quiet while reset is held so that a reset
        // asserted mid-cycle leaves no residual stall even before the
        // asynchronous state clear has propagated through inputs.
        if (rst_n) begin
            unique case (state_q)
                RUN: begin
                    if (bus.dmem_busy) begin
                        // Freeze everything up to MEM; EX inputs are held so
                        // a pending branch/hazard is re-evaluated later.
                        w_pc_stall    = 1'b1;
                        w_ifid_stall  = 1'b1;
                        w_idex_stall  = 1'b1;
                        w_exmem_stall = 1'b1;
                        w_memwb_flush = 1'b1;
                    end else if (bus.ex_branch_taken) begin
                        // Squashes whatever sits in IF and ID, including a
                        // hazard-causing instruction or an ECALL.
                        w_ifid_flush  = 1'b1;
                        w_idex_flush  = 1'b1;
                    end else if (bus.ecall_id) begin
                        w_pc_stall    = 1'b1;
                        w_ifid_stall  = 1'b1;
                        w_idex_flush  = 1'b1;
                        state_d       = DRAIN;
                        drain_d       = DRAIN_W'(DRAIN_CYCLES);
                    end else if (w_hazard) begin
                        w_pc_stall    = 1'b1;
                        w_ifid_stall  = 1'b1;
                        w_idex_flush  = 1'b1;
                    end else if (!bus.imem_valid) begin
                        w_pc_stall    = 1'b1;
                        w_ifid_flush  = 1'b1;
                    end
                end

                DRAIN: begin
                    // Branches are ignored here: anything older than the
                    // ECALL was resolved before it reached ID.
                    w_pc_stall   = 1'b1;
                    w_ifid_stall = 1'b1;
                    if (bus.dmem_busy) begin
                        w_idex_stall  = 1'b1;
                        w_exmem_stall = 1'b1;
                        w_memwb_flush = 1'b1;
                    end else begin
                        w_idex_flush = 1'b1;
                        drain_d      = drain_q - DRAIN_W'(1);
                        if (drain_q == DRAIN_W'(1)) begin
                            state_d = HALTED;
                        end
                    end
                end

                HALTED: begin
                    w_pc_stall   = 1'b1;
                    w_ifid_stall = 1'b1;
                    w_idex_flush = 1'b1;
                    w_halt       = 1'b1;
                end

                default: begin
                    state_d = RUN;
                    drain_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (w_pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if ((w_ifid_flush || w_idex_flush) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.pc_stall    = w_pc_stall;
    assign bus.ifid_stall  = w_ifid_stall;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_stall  = w_idex_stall;
    assign bus.idex_flush  = w_idex_flush;
    assign bus.exmem_stall = w_exmem_stall;
    assign bus.memwb_flush = w_memwb_flush;
    assign bus.halt        = w_halt;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;

endmodule : pipe_hazard_ctrl
`default_nettype wire
